// File: rtl/spi_exec_dispatcher.sv
// rtl/spi_exec_dispatcher.sv - SPI master dispatching execute-stage operations to serial functional units
module spi_exec_dispatcher #(
  parameter int N_SLAVES = 3,
  parameter int DATA_W   = 16,
  parameter int OP_W     = 3,
  parameter int TIMEOUT  = 64
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [$clog2(N_SLAVES)-1:0] req_slave,
  input  logic [OP_W-1:0]             req_op,
  input  logic [DATA_W-1:0]           req_opa,
  input  logic [DATA_W-1:0]           req_opb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        rsp_err,
  output logic                        o_busy,
  output logic                        spi_sclk,
  output logic [N_SLAVES-1:0]         spi_nss,
  output logic                        spi_mosi,
  input  logic [N_SLAVES-1:0]         spi_miso
);
  localparam int SEL_W  = $clog2(N_SLAVES);
  localparam int PKT_W  = 2 * DATA_W + OP_W;
  localparam int BIT_W  = $clog2(PKT_W);
  localparam int RX_W   = $clog2(DATA_W);
  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(PKT_W - 1);
  localparam logic [RX_W-1:0]   RX_LAST   = RX_W'(DATA_W - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [SEL_W:0]    SEL_LIMIT = (SEL_W + 1)'(N_SLAVES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_SHIFT  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_RECV   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [PKT_W-1:0]  pkt_q, pkt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [RX_W-1:0]   rx_cnt_q, rx_cnt_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              miso_sel;
  logic              link_active;

  assign spi_sclk    = i_clock;
  assign req_ready   = (state_q == S_IDLE);
  assign o_busy      = (state_q != S_IDLE);
  assign rsp_valid   = (state_q == S_DONE);
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign miso_sel    = spi_miso[sel_q];
  assign link_active = (state_q == S_SELECT) || (state_q == S_START) || (state_q == S_SHIFT) ||
                       (state_q == S_WAIT) || (state_q == S_RECV);

  always_comb begin
    spi_nss = '1;
    if (link_active) spi_nss[sel_q] = 1'b0;
  end

  // The packet register shifts right, so bit 0 always carries the next outgoing bit.
  always_comb begin
    case (state_q)
      S_START: spi_mosi = 1'b1;
      S_SHIFT: spi_mosi = pkt_q[0];
      default: spi_mosi = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    pkt_d      = pkt_q;
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          sel_d      = req_slave;
          pkt_d      = {req_opa, req_opb, req_op};
          bit_cnt_d  = '0;
          wait_cnt_d = '0;
          rx_cnt_d   = '0;
          rsp_data_d = '0;
          if ({1'b0, req_slave} >= SEL_LIMIT) begin
            rsp_err_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            rsp_err_d = 1'b0;
            state_d   = S_SELECT;
          end
        end
      end
      S_SELECT: state_d = S_START;
      S_START:  state_d = S_SHIFT;
      S_SHIFT: begin
        pkt_d     = pkt_q >> 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (miso_sel) begin
          rx_cnt_d = '0;
          state_d  = S_RECV;
        end else if ((TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST)) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = S_DONE;
        end
      end
      S_RECV: begin
        // Result arrives LSB first; after DATA_W shifts the first bit sits in bit 0.
        rsp_data_d = {miso_sel, rsp_data_q[DATA_W-1:1]};
        rx_cnt_d   = rx_cnt_q + 1'b1;
        if (rx_cnt_q == RX_LAST) begin
          rsp_err_d = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      pkt_q      <= '0;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      rx_cnt_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      pkt_q      <= pkt_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_spi_exec_dispatcher.sv
// tb/tb_spi_exec_dispatcher.sv - self-checking bench for spi_exec_dispatcher
module tb_spi_exec_dispatcher;
  localparam int NS  = 3;
  localparam int DW  = 16;
  localparam int OW  = 3;
  localparam int TO  = 64;
  localparam int PKT = 2 * DW + OW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_slave = '0;
  logic [2:0]  req_op = '0;
  logic [15:0] req_opa = '0;
  logic [15:0] req_opb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        sclk;
  logic [2:0]  nss;
  logic        mosi;
  logic [2:0]  miso;

  int          slv_idx = 0;
  logic        slv_bit = 1'b0;
  logic [2:0]  noise = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;

  // transaction-level reference
  bit          m_active = 1'b0;
  int          m_cyc = 0;
  int          m_done = 0;
  int          m_sel = 0;
  logic [34:0] m_pkt = '0;
  logic [15:0] m_data = '0;
  logic        m_err = 1'b0;
  int          tb_k = 1;
  logic [15:0] tb_val = '0;
  bit          tb_to = 1'b0;

  spi_exec_dispatcher #(.N_SLAVES(NS), .DATA_W(DW), .OP_W(OW), .TIMEOUT(TO)) dut (
    .i_clock(clk), .i_reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_slave(req_slave),
    .req_op(req_op), .req_opa(req_opa), .req_opb(req_opb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .o_busy(busy), .spi_sclk(sclk), .spi_nss(nss), .spi_mosi(mosi), .spi_miso(miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < NS; i++) miso[i] = (slv_idx == i) ? slv_bit : noise[i];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Edges counted from the accept edge: 0 = SELECT, 1 = start bit, 2..PKT+1 = packet bits.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (m_cyc >= m_done && rsp_ready) m_active = 1'b0;
      else m_cyc++;
    end else if (req_valid) begin
      m_active = 1'b1;
      m_cyc    = 0;
      m_sel    = int'(req_slave);
      m_pkt    = {req_opa, req_opb, req_op};
      if (m_sel >= NS) begin
        m_done = 0; m_err = 1'b1; m_data = '0;
      end else if (tb_to) begin
        m_done = 2 + PKT + TO; m_err = 1'b1; m_data = '0;
      end else begin
        m_done = 2 + PKT + tb_k + DW; m_err = 1'b0; m_data = tb_val;
      end
    end
  end

  always @(negedge clk) begin
    logic [2:0] e_nss;
    logic       e_mosi;
    logic       e_valid;
    e_valid = m_active && (m_cyc >= m_done);
    e_nss   = 3'b111;
    e_mosi  = 1'b0;
    if (m_active && m_cyc < m_done) begin
      e_nss[m_sel] = 1'b0;
      if (m_cyc == 1) e_mosi = 1'b1;
      else if (m_cyc >= 2 && m_cyc < 2 + PKT) e_mosi = m_pkt[m_cyc-2];
    end
    check("req_ready", req_ready, !m_active);
    check("o_busy", busy, m_active);
    check("rsp_valid", rsp_valid, e_valid);
    check("spi_nss", nss, e_nss);
    check("spi_mosi", mosi, e_mosi);
    if (e_valid) begin
      check("rsp_data", rsp_data, m_data);
      check("rsp_err", rsp_err, m_err);
    end
  end

  task automatic slave_respond(input int s, input int k, input bit echo, input logic [15:0] cval,
                               output logic [34:0] rx);
    logic [15:0] v;
    int n;
    rx = '0;
    slv_idx = s;
    slv_bit = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(nss[s] == 1'b0 && mosi == 1'b1) && n < 200);
    if (n >= 200) begin
      fail_now("slave_start");
      return;
    end
    for (int i = 0; i < PKT; i++) begin
      @(negedge clk);
      rx[i] = mosi;
    end
    v = echo ? rx[34:19] + rx[18:3] : cval;
    repeat (k) @(negedge clk);
    slv_bit = 1'b1;
    for (int j = 0; j < DW; j++) begin
      @(negedge clk);
      slv_bit = v[j];
    end
    @(negedge clk);
    slv_bit = 1'b0;
  endtask

  task automatic issue(input logic [1:0] s, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input int k, input logic [15:0] val, input bit to);
    int n;
    n = 0;
    tb_k = k; tb_val = val; tb_to = to;
    req_slave = s; req_op = op; req_opa = a; req_opb = b;
    req_valid = 1'b1;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) fail_now("accept");
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    req_slave = 2'($urandom_range(0, 3));
    req_op    = 3'($urandom);
    req_opa   = 16'($urandom);
    req_opb   = 16'($urandom);
  endtask

  task automatic wait_rsp(output int lat);
    int n;
    n = 0;
    while (!rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) fail_now("rsp_wait");
    lat = cyc - acc_cyc;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int rdy_cyc;
    logic [34:0] rx1, rx2, rx3;

    repeat (2) @(negedge clk);
    check("rst_nss", nss, 3'b111);
    check("rst_mosi", mosi, 1'b0);
    check("rst_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_data", rsp_data, 16'h0000);
    check("rst_err", rsp_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: echo slave 0, k=1
    fork
      slave_respond(0, 1, 1'b1, 16'h0000, rx1);
      begin issue(2'd0, 3'd0, 16'h0003, 16'h0004, 1, 16'h0007, 1'b0); wait_rsp(lat); end
      begin repeat (30) @(negedge clk); check("t1_nss_mid", nss, 3'b110); end
    join
    check("t1_latency", lat, 54);
    check("t1_data", rsp_data, 16'h0007);
    check("t1_err", rsp_err, 1'b0);
    check("t1_packet", rx1, 35'h0_0018_0020);
    @(negedge clk);

    // 2: slave 2, k=5, noise on the unselected lines
    fork
      slave_respond(2, 5, 1'b0, 16'hC000, rx2);
      begin issue(2'd2, 3'd5, 16'h8001, 16'h0001, 5, 16'hC000, 1'b0); wait_rsp(lat); end
      begin
        repeat (80) begin @(negedge clk); noise = 3'($urandom_range(0, 3)); end
        noise = '0;
      end
    join
    check("t2_latency", lat, 58);
    check("t2_data", rsp_data, 16'hC000);
    check("t2_packet", rx2, 35'h4_0008_000D);
    @(negedge clk);

    // 3: invalid slave index
    issue(2'd3, 3'd1, 16'h1234, 16'h5678, 1, 16'h0000, 1'b0);
    wait_rsp(lat);
    check("t3_latency", lat, 0);
    check("t3_err", rsp_err, 1'b1);
    check("t3_data", rsp_data, 16'h0000);
    check("t3_nss", nss, 3'b111);
    @(negedge clk);

    // 4: silent slave, timeout
    issue(2'd1, 3'd2, 16'h0F0F, 16'hF0F0, 1, 16'h0000, 1'b1);
    wait_rsp(lat);
    check("t4_latency", lat, 2 + PKT + TO);
    check("t4_err", rsp_err, 1'b1);
    check("t4_data", rsp_data, 16'h0000);
    check("t4_nss", nss, 3'b111);
    @(negedge clk);

    // 5: stalled consumer, queued second request
    rsp_ready = 1'b0;
    fork
      slave_respond(1, 3, 1'b0, 16'h1234, rx3);
      begin issue(2'd1, 3'd6, 16'h00FF, 16'hFF00, 3, 16'h1234, 1'b0); wait_rsp(lat); end
    join
    check("t5_latency", lat, 56);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_hold_valid", rsp_valid, 1'b1);
      check("t5_hold_data", rsp_data, 16'h1234);
      check("t5_hold_ready", req_ready, 1'b0);
    end
    fork
      slave_respond(0, 2, 1'b1, 16'h0000, rx3);
      begin issue(2'd0, 3'd1, 16'h1111, 16'h0101, 2, 16'h1212, 1'b0); wait_rsp(lat); end
      begin rdy_cyc = cyc; rsp_ready = 1'b1; end
    join
    check("t5_accept_gap", acc_cyc - rdy_cyc, 2);
    check("t5_latency2", lat, 55);
    check("t5_data2", rsp_data, 16'h1212);
    @(negedge clk);

    // 6: reset mid-SHIFT at bit 17, then a fresh transaction
    issue(2'd2, 3'd7, 16'hA5A5, 16'h5A5A, 1, 16'h0000, 1'b0);
    repeat (19) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_nss", nss, 3'b111);
    check("t6_mosi", mosi, 1'b0);
    check("t6_ready", req_ready, 1'b1);
    check("t6_busy", busy, 1'b0);
    check("t6_valid", rsp_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fork
      slave_respond(2, 1, 1'b1, 16'h0000, rx3);
      begin issue(2'd2, 3'd0, 16'h1111, 16'h2222, 1, 16'h3333, 1'b0); wait_rsp(lat); end
    join
    check("t6_latency", lat, 54);
    check("t6_data", rsp_data, 16'h3333);
    check("t6_err", rsp_err, 1'b0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_exec_dispatcher.md
Name: spi_exec_dispatcher

Overview:
Parametrised SPI master that offloads execute-stage operations to N_SLAVES serial functional units (ALU, multiplier, shifter, ...) over one shared SPI bus.
- Accepts one operation per valid/ready handshake from the execute stage.
- Serialises the packet {opa, opb, op} with a start bit, waits for the selected slave's response start bit, then deserialises the result.
- Returns the result through a valid/ready response port, with a per-transaction timeout and error flag.
- Replaces the hard-wired 3-slave dispatch logic inside the processor.

Parameters:
N_SLAVES, 3, number of SPI slaves and width of nss/miso
DATA_W, 16, operand and result width
OP_W, 3, opcode width
TIMEOUT, 64, maximum WAIT_RSP cycles before error; 0 disables the timeout

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous active-low reset
req_valid  in  1  operation request valid
req_ready  out  1  dispatcher can accept a request
req_slave  in  $clog2(N_SLAVES)  target slave index
req_op  in  OP_W  opcode
req_opa  in  DATA_W  operand A
req_opb  in  DATA_W  operand B
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_data  out  DATA_W  result
rsp_err  out  1  invalid slave index or timeout
o_busy  out  1  transaction in flight; the pipeline stalls on this
spi_sclk  out  1  equals i_clock; both sides sample on posedge
spi_nss  out  N_SLAVES  active-low slave selects
spi_mosi  out  1  master-to-slave data
spi_miso  in  N_SLAVES  per-slave slave-to-master data

Behaviour:
- Reset (asynchronous, also mid-transaction):
  - state=IDLE, spi_nss all ones, spi_mosi=0.
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - All counters cleared, req_ready=1, o_busy=0.
- Packet: PKT_W = 2*DATA_W+OP_W, packet = {opa, opb, op}, sent LSB first, so the opcode goes first. Result is received LSB first.
- req_ready = (state==IDLE); o_busy = (state!=IDLE).
- IDLE:
  - On req_valid&&req_ready, latch slave, op, opa and opb.
  - If req_slave>=N_SLAVES: go to DONE with rsp_err=1, rsp_data=0, and never assert nss.
  - Otherwise go to SELECT.
- SELECT, 1 cycle: nss[sel]=0, mosi=0.
- START, 1 cycle: mosi=1 (start bit).
- SHIFT, PKT_W cycles: mosi = packet[bit_cnt]; bit_cnt counts 0..PKT_W-1, then the state goes to WAIT_RSP.
- WAIT_RSP:
  - mosi=0; nss[sel] stays low.
  - miso[sel]==1 sampled at a posedge: go to RECV with rx_cnt=0.
  - Timeout: if TIMEOUT!=0 and the wait counter reaches TIMEOUT, go to DONE with rsp_err=1, rsp_data=0.
- RECV, DATA_W cycles: result[rx_cnt] = miso[sel] sampled each posedge; after DATA_W bits, go to DONE with rsp_err=0.
- DONE:
  - nss all ones; rsp_valid=1; rsp_data and rsp_err held stable.
  - On rsp_ready go to IDLE, clearing rsp_valid the same edge.
- rsp_valid holds indefinitely while rsp_ready=0; no new request is accepted meanwhile.
- Only miso[sel] is observed. Other miso lines and their activity are ignored in every state.
- At most one nss bit is low at any time. nss is low only in SELECT, START, SHIFT, WAIT_RSP and RECV.
- Latency: rsp_valid rises 2+PKT_W+k+DATA_W edges after the accept edge, where k≥1 is the WAIT_RSP cycles up to and including the one where the start bit is sampled.
- Back-to-back:
  - A request presented while rsp_valid=1 is accepted the cycle after the DONE→IDLE edge.
  - No combinational req_ready depends on rsp_ready.
- Request inputs are not used after the accept edge; changing them mid-transaction has no effect.

Test Plan:
1. Default params; slave 0 model echoes opa+opb 1 cycle after SHIFT ends; req op=0, opa=0x0003, opb=0x0004 -> mosi shows 1 then 35 packet bits LSB-first; rsp_valid 54 edges after accept (k=1); rsp_data=0x0007, rsp_err=0; nss=3'b110 throughout the transaction.
2. req_slave=2, op=5, opa=0x8001, opb=0x0001, slave returns 0xC000 after k=5 -> only nss[2] low; rsp_data=0xC000; toggling miso[0] and miso[1] in the meantime has no effect.
3. req_slave=3 (invalid) -> nss stays 3'b111; rsp_valid on the next edge with rsp_err=1, rsp_data=0.
4. Selected slave never raises miso, TIMEOUT=64 -> after 64 WAIT_RSP cycles the state is DONE, rsp_err=1, rsp_data=0, nss=3'b111.
5. rsp_ready held 0 for 10 cycles after rsp_valid -> rsp_valid, rsp_data and rsp_err stable, req_ready=0; a second request queued on req_valid is accepted the cycle after rsp_ready=1 and produces a correct second result.
6. Assert i_reset=0 mid-SHIFT (bit 17) -> nss=3'b111, mosi=0, req_ready=1, o_busy=0 immediately; after release, a fresh request completes correctly.
